// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - spike-train to firing-rate word decoder with valid/ready output
module spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 8,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   spike,
  output logic [CNT_W-1:0]       rate,
  output logic                   rate_valid,
  input  logic                   rate_ready,
  output logic                   overrun,
  output logic [WINDOW_LOG2-1:0] win_pos
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]       CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WINDOW_LOG2-1:0] POS_LAST = '1;
  localparam logic [WINDOW_LOG2-1:0] POS_ONE  = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic             spike_d;
  logic             spike_edge;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_sum;
  logic             counting;
  logic             win_end;
  logic             xfer;

  assign spike_edge = spike & ~spike_d;
  assign xfer       = rate_valid & rate_ready;

  always_comb begin
    count_sum = count;
    if (spike_edge && (count != CNT_MAX)) begin
      count_sum = count + CNT_ONE;
    end
  end

  // A COUNT cycle with enable low discards the partial window instead of counting.
  always_comb begin
    state_next = state;
    counting   = 1'b0;
    win_end    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_next = IDLE;
        end else begin
          counting = 1'b1;
          win_end  = (win_pos == POS_LAST);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_d    <= 1'b0;
      count      <= '0;
      win_pos    <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      spike_d <= spike;
      if (counting) begin
        win_pos <= win_pos + POS_ONE;
        count   <= win_end ? '0 : count_sum;
      end else begin
        win_pos <= '0;
        count   <= '0;
      end
      // A window end wins over a same-cycle transfer, so valid stays high with the new rate.
      if (win_end) begin
        rate       <= count_sum;
        rate_valid <= 1'b1;
        if (rate_valid && !rate_ready) begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        rate_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - scoreboard bench for spike_rate_decoder (16-cycle window, 3-bit rate)
module tb_spike_rate_decoder;

  localparam int WL   = 4;
  localparam int CW   = 3;
  localparam int WLEN = 1 << WL;
  localparam int RMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          spike = 1'b0;
  logic          rate_ready = 1'b0;
  logic [CW-1:0] rate;
  logic          rate_valid;
  logic          overrun;
  logic [WL-1:0] win_pos;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  bit m_on   = 1'b0;
  bit m_prev = 1'b0;
  bit m_out  = 1'b0;
  bit m_ovr  = 1'b0;
  bit m_win[$];
  int exp_q[$];

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_LOG2(WL), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .spike     (spike),
    .rate      (rate),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .overrun   (overrun),
    .win_pos   (win_pos)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: collect per-window rising-edge flags, total them when the window fills.
  task automatic model(input bit rst, input bit en, input bit sp, input bit rdy);
    int n;
    if (rst) begin
      m_on = 0; m_prev = 0; m_out = 0; m_ovr = 0;
      m_win.delete();
      exp_q.delete();
      return;
    end
    if (m_out && rdy) m_out = 0;
    if (!m_on) begin
      if (en) begin
        m_on = 1;
        m_win.delete();
      end
    end else if (!en) begin
      m_on = 0;
      m_win.delete();
    end else begin
      m_win.push_back(sp && !m_prev);
      if (m_win.size() == WLEN) begin
        n = 0;
        foreach (m_win[k]) n += int'(m_win[k]);
        if (n > RMAX) n = RMAX;
        if (m_out) begin
          void'(exp_q.pop_back());
          m_ovr = 1;
        end
        exp_q.push_back(n);
        m_out = 1;
        m_win.delete();
      end
    end
    m_prev = sp;
  endtask

  task automatic cyc(input bit rst, input bit en, input bit sp, input bit rdy);
    reset = rst; enable = en; spike = sp; rate_ready = rdy;
    @(posedge clk);
    #1;
    model(rst, en, sp, rdy);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("rate_valid", int'(rate_valid), int'(exp_q.size() != 0));
      check("overrun", int'(overrun), int'(m_ovr));
      check("win_pos", int'(win_pos), m_win.size());
      if (rate_valid && rate_ready && exp_q.size() > 0) begin
        check("rate", int'(rate), exp_q.pop_front());
      end
    end
  end

  initial begin
    // 1: reset with spike toggling
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 1);
    mon_on = 1'b1;
    check("reset rate", int'(rate), 0);
    check("reset valid", int'(rate_valid), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset win_pos", int'(win_pos), 0);
    cyc(0, 0, 0, 1);

    // 2: one spike every 4 cycles
    cyc(0, 1, 0, 1);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, (i % 4) == 0, 1);
    check("t2 valid", int'(rate_valid), 1);
    check("t2 rate", int'(rate), 4);
    cyc(0, 0, 0, 1);
    check("t2 pulse", int'(rate_valid), 0);

    // 3: held spike counts once; already-high spike not counted
    cyc(0, 1, 0, 1);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, 1, 1);
    check("t3 held rate", int'(rate), 1);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, 1, 1);
    check("t3 pre-high rate", int'(rate), 0);
    check("t3 pre-high valid", int'(rate_valid), 1);
    cyc(0, 0, 0, 1);

    // 4: saturation
    cyc(0, 1, 0, 1);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, (i % 2) == 0, 1);
    check("t4 sat rate", int'(rate), RMAX);
    cyc(0, 0, 0, 1);

    // 5: overrun, then ready in the window-end cycle
    cyc(0, 1, 0, 0);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, (i % 4) == 0 && i < 12, 0);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, (i % 2) == 0 && i < 10, 0);
    check("t5 rate", int'(rate), 5);
    check("t5 overrun", int'(overrun), 1);
    check("t5 valid", int'(rate_valid), 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, (i % 4) == 0 && i < 12, 0);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, (i % 2) == 0 && i < 10, i == WLEN - 1);
    check("t5b rate", int'(rate), 5);
    check("t5b overrun", int'(overrun), 0);
    check("t5b valid", int'(rate_valid), 1);
    cyc(0, 0, 0, 1);

    // 6: enable drop and reset mid-window
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, (i % 4) == 0, 1);
    check("t6 win_pos", int'(win_pos), 9);
    cyc(0, 0, 0, 1);
    check("t6 drop win_pos", int'(win_pos), 0);
    check("t6 drop valid", int'(rate_valid), 0);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, (i % 2) == 0, 1);
    cyc(1, 1, 0, 1);
    check("t6 reset win_pos", int'(win_pos), 0);
    cyc(0, 1, 0, 1);
    for (int i = 0; i < WLEN; i++) cyc(0, 1, i == 3 || i == 10, 1);
    check("t6 post-reset rate", int'(rate), 2);
    cyc(0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 999) < 3), ($urandom_range(0, 99) < 96),
          ($urandom_range(0, 99) < 30), ($urandom_range(0, 1) == 1));
    end

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    check("drained", exp_q.size(), 0);
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
